// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the synchronous instruction memory.
package imem_pkg;

  // Clear FSM states: CLEAR zero-fills the array, READY serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Instruction NOP encoding (all zeros); narrowed/widened to DATA_W at use.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // True when a word address addresses an implemented word.
  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    logic ok;
    if (addr < depth) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch and load handshake bundle of the instruction memory.
// The master side is the processor / boot loader, the slave side is imem_sync.
interface imem_sync_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, load_en, load_addr, load_data,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, load_ready, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_en, load_addr, load_data,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, load_ready, busy
  );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: one-read, one-write array with a registered (read-first) read port.
// The array itself is not reset; only the read register is.
module imem_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Array write; callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Synchronous read; holds the last word while no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rd_q <= mem_q[ra_i];
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/imem_sync.sv
// imem_sync: synchronous instruction memory with clear FSM, fetch/load
// handshake, range checking and optional write-first forwarding.
// Build option: define IMEM_BYPASS_EN to forward load_data to a same-cycle,
// same-address fetch; otherwise such a fetch returns the old contents.
module imem_sync
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic        clk,
  input  logic        rst,
  imem_sync_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              ready_s;
  logic              fetch_acc_s;
  logic              fetch_in_s;
  logic              load_ok_s;
  logic              byp_hit_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_wa_s;
  logic [DATA_W-1:0] ram_wd_s;
  logic [DATA_W-1:0] ram_rd_s;

  logic              fetch_valid_q;
  logic              oor_q;
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;

  assign ready_s     = (state_q == READY);
  assign fetch_acc_s = ready_s & bus.fetch_req;
  assign fetch_in_s  = in_range(32'(bus.fetch_addr), 32'(DEPTH));
  assign load_ok_s   = ready_s & bus.load_en & in_range(32'(bus.load_addr), 32'(DEPTH));

`ifdef IMEM_BYPASS_EN
  assign byp_hit_s = fetch_acc_s & fetch_in_s & load_ok_s & (bus.fetch_addr == bus.load_addr);
`else
  assign byp_hit_s = 1'b0;
`endif

  // State and clear-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state and RAM write-port steering: zero-fill in CLEAR, loads in READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we_s  = 1'b0;
    ram_wa_s  = bus.load_addr;
    ram_wd_s  = bus.load_data;
    case (state_q)
      CLEAR: begin
        ram_we_s = 1'b1;
        ram_wa_s = clr_cnt_q;
        ram_wd_s = DATA_W'(NOP_WORD);
        // Stop on the last word so the counter never wraps when DEPTH == 2**ADDR_W.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = READY;
          clr_cnt_d = {ADDR_W{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      READY: begin
        ram_we_s = load_ok_s;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Fetch response registers; selectors hold so fetch_data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      oor_q         <= 1'b0;
      byp_q         <= 1'b0;
      byp_data_q    <= {DATA_W{1'b0}};
    end else begin
      fetch_valid_q <= fetch_acc_s;
      if (fetch_acc_s) begin
        oor_q <= ~fetch_in_s;
        byp_q <= byp_hit_s;
        if (byp_hit_s) begin
          byp_data_q <= bus.load_data;
        end
      end
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we_i (ram_we_s),
    .wa_i (ram_wa_s),
    .wd_i (ram_wd_s),
    .re_i (fetch_acc_s & fetch_in_s),
    .ra_i (bus.fetch_addr),
    .rd_o (ram_rd_s)
  );

  assign bus.fetch_ready = ready_s;
  assign bus.load_ready  = ready_s;
  assign bus.busy        = ~ready_s;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_valid_q & oor_q;
  assign bus.fetch_data  = oor_q ? {DATA_W{1'b0}} : (byp_q ? byp_data_q : ram_rd_s);

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed self-checking bench for imem_sync (DEPTH=64 and DEPTH=40).
module tb_imem_sync;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] prog [8];

  imem_sync_if #(.ADDR_W(6), .DATA_W(32)) bus64 ();
  imem_sync_if #(.ADDR_W(6), .DATA_W(32)) bus40 ();

  imem_sync #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  imem_sync #(.ADDR_W(6), .DATA_W(32), .DEPTH(40)) dut40 (
    .clk (clk),
    .rst (rst),
    .bus (bus40)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle64();
    bus64.fetch_req  = 1'b0;
    bus64.fetch_addr = 6'd0;
    bus64.load_en    = 1'b0;
    bus64.load_addr  = 6'd0;
    bus64.load_data  = 32'h0;
  endtask

  task automatic idle40();
    bus40.fetch_req  = 1'b0;
    bus40.fetch_addr = 6'd0;
    bus40.load_en    = 1'b0;
    bus40.load_addr  = 6'd0;
    bus40.load_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle64();
    idle40();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus64.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", bus64.busy); end
    checks++; if (bus64.fetch_ready !== 1'b0) begin errors++; $display("FAIL rst_fready got %b want 0", bus64.fetch_ready); end
    checks++; if (bus64.load_ready !== 1'b0) begin errors++; $display("FAIL rst_lready got %b want 0", bus64.load_ready); end
    checks++; if (bus64.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus64.fetch_valid); end
    checks++; if (bus64.fetch_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus64.fetch_data); end
    checks++; if (bus64.fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus64.fetch_err); end
  endtask

  // Release reset with requests held high for the whole CLEAR window.
  task automatic test_clear_requests();
    @(negedge clk);
    bus64.fetch_req  = 1'b1;
    bus64.fetch_addr = 6'd2;
    bus64.load_en    = 1'b1;
    bus64.load_addr  = 6'd2;
    bus64.load_data  = 32'hFFFF_FFFF;
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (i < 64) begin
        if (bus64.busy !== 1'b1 || bus64.fetch_valid !== 1'b0) begin
          errors++; $display("FAIL clear_cycle%0d busy=%b valid=%b want busy=1 valid=0", i, bus64.busy, bus64.fetch_valid);
        end
      end else begin
        if (bus64.busy !== 1'b0 || bus64.fetch_ready !== 1'b1 || bus64.load_ready !== 1'b1 || bus64.fetch_valid !== 1'b0) begin
          errors++; $display("FAIL clear_end busy=%b fready=%b lready=%b valid=%b want 0 1 1 0",
                             bus64.busy, bus64.fetch_ready, bus64.load_ready, bus64.fetch_valid);
        end
      end
    end
    @(negedge clk);
    idle64();
    bus64.fetch_req  = 1'b1;
    bus64.fetch_addr = 6'd2;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== 32'h0) begin
      errors++; $display("FAIL clear_addr2 valid=%b data=%h want 1 00000000", bus64.fetch_valid, bus64.fetch_data);
    end
    @(negedge clk);
    idle64();
  endtask

  task automatic test_fetch_zero();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus64.fetch_req  = 1'b1;
      bus64.fetch_addr = 6'(i);
      @(posedge clk);
      #1;
      checks++;
      if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== 32'h0 || bus64.fetch_err !== 1'b0) begin
        errors++; $display("FAIL zero_addr%0d valid=%b data=%h err=%b want 1 00000000 0",
                           i, bus64.fetch_valid, bus64.fetch_data, bus64.fetch_err);
      end
    end
    @(negedge clk);
    idle64();
    @(posedge clk);
    #1;
    checks++; if (bus64.fetch_valid !== 1'b0) begin errors++; $display("FAIL zero_idle valid=%b want 0", bus64.fetch_valid); end
  endtask

  task automatic test_back_to_back();
    prog[0] = 32'h00001820; prog[1] = 32'h2001000A; prog[2] = 32'h00231820; prog[3] = 32'hAC030001;
    prog[4] = 32'h28210001; prog[5] = 32'h00012029; prog[6] = 32'h1480FFFB; prog[7] = 32'h8C030001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus64.load_en   = 1'b1;
      bus64.load_addr = 6'(i);
      bus64.load_data = prog[i];
    end
    @(negedge clk);
    idle64();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus64.fetch_req  = 1'b1;
      bus64.fetch_addr = 6'(i);
      @(posedge clk);
      #1;
      checks++;
      if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== prog[i] || bus64.fetch_err !== 1'b0) begin
        errors++; $display("FAIL b2b_addr%0d valid=%b data=%h want 1 %h", i, bus64.fetch_valid, bus64.fetch_data, prog[i]);
      end
    end
    @(negedge clk);
    idle64();
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b0 || bus64.fetch_data !== 32'h8C030001) begin
      errors++; $display("FAIL b2b_hold valid=%b data=%h want 0 8c030001", bus64.fetch_valid, bus64.fetch_data);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus40.load_en   = 1'b1;
    bus40.load_addr = 6'd5;
    bus40.load_data = 32'h1234_5678;
    @(negedge clk);
    idle40();
    bus40.fetch_req  = 1'b1;
    bus40.fetch_addr = 6'd45;
    @(posedge clk);
    #1;
    checks++;
    if (bus40.fetch_valid !== 1'b1 || bus40.fetch_err !== 1'b1 || bus40.fetch_data !== 32'h0) begin
      errors++; $display("FAIL oor45 valid=%b err=%b data=%h want 1 1 00000000", bus40.fetch_valid, bus40.fetch_err, bus40.fetch_data);
    end
    @(negedge clk);
    idle40();
    bus40.load_en   = 1'b1;
    bus40.load_addr = 6'd45;
    bus40.load_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    checks++; if (bus40.fetch_err !== 1'b0) begin errors++; $display("FAIL oor_err_idle err=%b want 0", bus40.fetch_err); end
    @(negedge clk);
    idle40();
    bus40.fetch_req  = 1'b1;
    bus40.fetch_addr = 6'd5;
    @(posedge clk);
    #1;
    checks++;
    if (bus40.fetch_valid !== 1'b1 || bus40.fetch_err !== 1'b0 || bus40.fetch_data !== 32'h1234_5678) begin
      errors++; $display("FAIL oor_addr5 valid=%b err=%b data=%h want 1 0 12345678", bus40.fetch_valid, bus40.fetch_err, bus40.fetch_data);
    end
    @(negedge clk);
    bus40.fetch_addr = 6'd39;
    @(posedge clk);
    #1;
    checks++;
    if (bus40.fetch_err !== 1'b0 || bus40.fetch_data !== 32'h0) begin
      errors++; $display("FAIL oor_addr39 err=%b data=%h want 0 00000000", bus40.fetch_err, bus40.fetch_data);
    end
    @(negedge clk);
    bus40.fetch_addr = 6'd40;
    @(posedge clk);
    #1;
    checks++;
    if (bus40.fetch_valid !== 1'b1 || bus40.fetch_err !== 1'b1 || bus40.fetch_data !== 32'h0) begin
      errors++; $display("FAIL oor_addr40 valid=%b err=%b data=%h want 1 1 00000000", bus40.fetch_valid, bus40.fetch_err, bus40.fetch_data);
    end
    @(negedge clk);
    idle40();
  endtask

  task automatic test_collision();
    logic [31:0] exp_col;
`ifdef IMEM_BYPASS_EN
    exp_col = 32'hDEAD_BEEF;
`else
    exp_col = 32'hAC03_0001;
`endif
    @(negedge clk);
    bus64.load_en    = 1'b1;
    bus64.load_addr  = 6'd3;
    bus64.load_data  = 32'hDEAD_BEEF;
    bus64.fetch_req  = 1'b1;
    bus64.fetch_addr = 6'd3;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== exp_col) begin
      errors++; $display("FAIL collide valid=%b data=%h want 1 %h", bus64.fetch_valid, bus64.fetch_data, exp_col);
    end
    @(negedge clk);
    bus64.load_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL collide_after valid=%b data=%h want 1 deadbeef", bus64.fetch_valid, bus64.fetch_data);
    end
    // Different addresses in the same cycle stay independent.
    @(negedge clk);
    bus64.load_en    = 1'b1;
    bus64.load_addr  = 6'd4;
    bus64.load_data  = 32'h1111_2222;
    bus64.fetch_addr = 6'd5;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_data !== 32'h0001_2029) begin
      errors++; $display("FAIL indep_addr5 data=%h want 00012029", bus64.fetch_data);
    end
    @(negedge clk);
    bus64.load_en    = 1'b0;
    bus64.fetch_addr = 6'd4;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_data !== 32'h1111_2222) begin
      errors++; $display("FAIL indep_addr4 data=%h want 11112222", bus64.fetch_data);
    end
    @(negedge clk);
    idle64();
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus64.busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got %b want 1", bus64.busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus64.busy !== 1'b1 || bus64.fetch_ready !== 1'b0) begin
      errors++; $display("FAIL midclr_rst busy=%b fready=%b want 1 0", bus64.busy, bus64.fetch_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (i == 63) begin
        checks++; if (bus64.busy !== 1'b1) begin errors++; $display("FAIL midclr_c63 busy=%b want 1", bus64.busy); end
      end else if (i == 64) begin
        checks++; if (bus64.busy !== 1'b0) begin errors++; $display("FAIL midclr_c64 busy=%b want 0", bus64.busy); end
      end
    end
    @(negedge clk);
    bus64.fetch_req  = 1'b1;
    bus64.fetch_addr = 6'd3;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== 32'h0) begin
      errors++; $display("FAIL midclr_refill valid=%b data=%h want 1 00000000", bus64.fetch_valid, bus64.fetch_data);
    end
    @(negedge clk);
    idle64();
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    bus64.load_en   = 1'b1;
    bus64.load_addr = 6'd0;
    bus64.load_data = 32'h5A5A_A5A5;
    @(negedge clk);
    idle64();
    bus64.fetch_req  = 1'b1;
    bus64.fetch_addr = 6'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b1 || bus64.fetch_data !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL midf_accept valid=%b data=%h want 1 5a5aa5a5", bus64.fetch_valid, bus64.fetch_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus64.fetch_valid !== 1'b0 || bus64.fetch_data !== 32'h0 || bus64.busy !== 1'b1) begin
      errors++; $display("FAIL midf_rst valid=%b data=%h busy=%b want 0 00000000 1", bus64.fetch_valid, bus64.fetch_data, bus64.busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++; if (bus64.fetch_valid !== 1'b0) begin errors++; $display("FAIL midf_hold valid=%b want 0", bus64.fetch_valid); end
    end
    @(negedge clk);
    idle64();
    rst = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    checks++; if (bus64.busy !== 1'b0) begin errors++; $display("FAIL midf_clear_done busy=%b want 0", bus64.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clear_requests();
    test_fetch_zero();
    test_back_to_back();
    test_out_of_range();
    test_collision();
    test_reset_mid_clear();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
